// File: rtl/bt_cmd_receiver.sv
// UART 8N1 receiver and motion-command decoder for the Bluetooth serial line.
// Accepts codes CMD_MIN..CMD_MAX into cmd and falls back to CMD_STOP when the link goes quiet.
module bt_cmd_receiver #(
    parameter int unsigned CLKS_PER_BIT   = 10417,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter logic [7:0]  CMD_MIN        = 8'd10,
    parameter logic [7:0]  CMD_MAX        = 8'd20,
    parameter logic [7:0]  CMD_STOP       = 8'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] cmd,
    output logic       cmd_valid,
    output logic [7:0] rx_byte,
    output logic       bad_cmd,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned      BcntW       = $clog2(CLKS_PER_BIT);
    localparam logic [BcntW-1:0] BitLast     = BcntW'(CLKS_PER_BIT - 1);
    localparam logic [BcntW-1:0] HalfLast    = BcntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]      TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
    localparam bit               TimeoutEn   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    state_e           state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [BcntW-1:0] bcnt_q, bcnt_d;
    logic [2:0]       bidx_q, bidx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_byte_q;
    logic [7:0]       cmd_q;
    logic [31:0]      tcnt_q;
    logic             cmd_valid_q, bad_cmd_q, frame_err_q;

    logic bit_end, stop_sample, good_stop, in_range;
    logic byte_ok, byte_bad, frame_bad, timeout_hit;

    assign bit_end = (bcnt_q == BitLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (!rx_s_q) state_d = StStart;
            StStart:    if (bcnt_q == HalfLast) state_d = rx_s_q ? StIdle : StData;
            StData:     if (bit_end && bidx_q == 3'd7) state_d = StStop;
            StStop:     if (bit_end) state_d = rx_s_q ? StIdle : StWaitIdle;
            StWaitIdle: if (rx_s_q) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        bcnt_d      = bcnt_q + 1'b1;
        bidx_d      = bidx_q;
        shift_d     = shift_q;
        stop_sample = 1'b0;
        busy        = (state_q != StIdle);
        unique case (state_q)
            StIdle, StWaitIdle: bcnt_d = '0;
            StStart: begin
                if (bcnt_q == HalfLast) begin
                    bcnt_d = '0;
                    bidx_d = '0;
                end
            end
            StData: begin
                // LSB first: after eight right-shifts bit 0 lands in shift[0]
                if (bit_end) begin
                    bcnt_d  = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bidx_d  = bidx_q + 3'd1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    bcnt_d      = '0;
                    stop_sample = 1'b1;
                end
            end
            default: bcnt_d = '0;
        endcase
    end

    assign good_stop   = stop_sample && rx_s_q;
    assign frame_bad   = stop_sample && !rx_s_q;
    assign in_range    = (shift_q >= CMD_MIN) && (shift_q <= CMD_MAX);
    assign byte_ok     = good_stop && in_range;
    assign byte_bad    = good_stop && !in_range;
    assign timeout_hit = TimeoutEn && (cmd_q != CMD_STOP) && (tcnt_q == TimeoutLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            bcnt_q      <= '0;
            bidx_q      <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            cmd_q       <= CMD_STOP;
            tcnt_q      <= '0;
            cmd_valid_q <= 1'b0;
            bad_cmd_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            bcnt_q      <= bcnt_d;
            bidx_q      <= bidx_d;
            shift_q     <= shift_d;
            cmd_valid_q <= byte_ok || timeout_hit;
            bad_cmd_q   <= byte_bad;
            frame_err_q <= frame_bad;
            if (good_stop) rx_byte_q <= shift_q;
            // A valid byte takes priority over a coincident timeout
            if (byte_ok) begin
                cmd_q  <= shift_q;
                tcnt_q <= '0;
            end else if (timeout_hit) begin
                cmd_q  <= CMD_STOP;
                tcnt_q <= '0;
            end else if (cmd_q == CMD_STOP || !TimeoutEn) begin
                tcnt_q <= '0;
            end else begin
                tcnt_q <= tcnt_q + 32'd1;
            end
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign rx_byte   = rx_byte_q;
    assign bad_cmd   = bad_cmd_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_bt_cmd_receiver.sv
// Directed bench for bt_cmd_receiver: framing, decode range, glitch, timeout, collision, reset.
module tb_bt_cmd_receiver;

    localparam int unsigned CPB = 16;
    localparam int unsigned TO  = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic [7:0] rx_byte;
    logic       bad_cmd;
    logic       frame_err;
    logic       busy;

    bt_cmd_receiver #(
        .CLKS_PER_BIT  (CPB),
        .TIMEOUT_CYCLES(TO),
        .CMD_MIN       (8'd10),
        .CMD_MAX       (8'd20),
        .CMD_STOP      (8'd10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .rx_byte  (rx_byte),
        .bad_cmd  (bad_cmd),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_valid = 0, n_bad = 0, n_ferr = 0, n_busy = 0;
    int t_last = 0;
    logic [7:0] valid_cmd = 8'h00;

    always @(negedge clk) begin
        if (cmd_valid) begin
            n_valid++;
            t_last    = cyc;
            valid_cmd = cmd;
        end
        if (bad_cmd) n_bad++;
        if (frame_err) n_ferr++;
        if (busy) n_busy++;
    end

    int n_checks = 0, n_pass = 0;
    int b_valid, b_bad, b_ferr, b_busy, t0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_valid = n_valid;
        b_bad   = n_bad;
        b_ferr  = n_ferr;
        b_busy  = n_busy;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
    endtask

    logic [7:0] bad_bytes[3] = '{8'h41, 8'h15, 8'h09};
    logic [7:0] fb;

    initial begin
        tick(3);
        check("reset_cmd", 32'(cmd), 32'h0A);
        check("reset_rx_byte", 32'(rx_byte), 32'h00);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_pulses", 32'({cmd_valid, bad_cmd, frame_err}), 32'h0);
        rst = 1'b0;
        tick(5);

        // Valid byte 0x0B; busy spans start detect to stop sample (152 cycles)
        snap();
        send(8'h0B, 1'b1);
        check("fwd_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("fwd_cmd", 32'(cmd), 32'd11);
        check("fwd_valid_cmd", 32'(valid_cmd), 32'd11);
        check("fwd_rx_byte", 32'(rx_byte), 32'h0B);
        check("fwd_no_bad", 32'(n_bad - b_bad), 32'd0);
        check("fwd_no_ferr", 32'(n_ferr - b_ferr), 32'd0);
        check("fwd_busy_len", 32'(n_busy - b_busy), 32'd152);
        check("fwd_idle", 32'(busy), 32'd0);

        for (int k = 0; k < 3; k++) begin
            snap();
            send(bad_bytes[k], 1'b1);
            tick(2);
            check("oor_bad_cnt", 32'(n_bad - b_bad), 32'd1);
            check("oor_no_valid", 32'(n_valid - b_valid), 32'd0);
            check("oor_cmd", 32'(cmd), 32'd11);
            check("oor_rx_byte", 32'(rx_byte), 32'(bad_bytes[k]));
        end
        snap();
        send(8'h14, 1'b1);
        check("max_cmd", 32'(cmd), 32'd20);
        check("max_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("max_no_bad", 32'(n_bad - b_bad), 32'd0);
        snap();
        send(8'h0A, 1'b1);
        check("min_cmd", 32'(cmd), 32'd10);
        check("min_valid_cnt", 32'(n_valid - b_valid), 32'd1);

        // Framing error followed by a held-low line
        snap();
        send(8'h0C, 1'b0);
        tick(100);
        check("ferr_cnt", 32'(n_ferr - b_ferr), 32'd1);
        check("ferr_wait_busy", 32'(busy), 32'd1);
        check("ferr_cmd", 32'(cmd), 32'd10);
        check("ferr_rx_byte", 32'(rx_byte), 32'h0A);
        check("ferr_no_valid", 32'(n_valid - b_valid), 32'd0);
        check("ferr_no_bad", 32'(n_bad - b_bad), 32'd0);
        rx = 1'b1;
        tick(4);
        check("ferr_release_idle", 32'(busy), 32'd0);
        snap();
        send(8'h0D, 1'b1);
        check("after_ferr_cmd", 32'(cmd), 32'd13);
        check("after_ferr_valid", 32'(n_valid - b_valid), 32'd1);
        check("after_ferr_no_ferr", 32'(n_ferr - b_ferr), 32'd0);

        // 4-cycle glitch: START for 8 cycles, then back to IDLE
        snap();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(20);
        check("glitch_busy_len", 32'(n_busy - b_busy), 32'd8);
        check("glitch_idle", 32'(busy), 32'd0);
        check("glitch_pulses",
              32'((n_valid - b_valid) + (n_bad - b_bad) + (n_ferr - b_ferr)), 32'd0);
        check("glitch_cmd", 32'(cmd), 32'd13);

        // Timeout after 1000 idle cycles
        snap();
        send(8'h10, 1'b1);
        t0 = t_last;
        check("to_cmd_set", 32'(cmd), 32'd16);
        tick(1100);
        check("to_valid_cnt", 32'(n_valid - b_valid), 32'd2);
        check("to_cmd_stop", 32'(cmd), 32'd10);
        check("to_valid_cmd", 32'(valid_cmd), 32'd10);
        check("to_delay", 32'(t_last - t0), 32'd1000);
        snap();
        tick(300);
        check("to_quiet", 32'(n_valid - b_valid), 32'd0);

        // Stop sample of 0x0F lands on the timeout expiry cycle
        send(8'h0B, 1'b1);
        t0 = t_last;
        check("col_pre_cmd", 32'(cmd), 32'd11);
        tick(840);
        snap();
        send(8'h0F, 1'b1);
        check("col_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("col_cmd", 32'(cmd), 32'd15);
        check("col_valid_cmd", 32'(valid_cmd), 32'd15);
        check("col_coincide", 32'(t_last - t0), 32'd1000);

        // Reset during bit 4 of a frame
        fb = 8'h12;
        snap();
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = fb[i];
            tick(CPB);
        end
        rx = fb[4];
        tick(8);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        rx  = 1'b1;
        check("rstmid_cmd", 32'(cmd), 32'd10);
        check("rstmid_rx_byte", 32'(rx_byte), 32'h00);
        check("rstmid_idle", 32'(busy), 32'd0);
        tick(200);
        check("rstmid_pulses",
              32'((n_valid - b_valid) + (n_bad - b_bad) + (n_ferr - b_ferr)), 32'd0);
        snap();
        send(8'h11, 1'b1);
        check("post_rst_cmd", 32'(cmd), 32'd17);
        check("post_rst_valid", 32'(n_valid - b_valid), 32'd1);
        check("post_rst_rx_byte", 32'(rx_byte), 32'h11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bt_cmd_receiver.md
Name: bt_cmd_receiver

Overview:
- UART 8N1 receiver and command decoder on the Bluetooth serial line.
- Produces the 8-bit motion command `cmd` that the car controller samples. This block is the writer side of the `cmd` interface.
- Accepts command bytes 10..20 and rejects everything else.
- Drops back to Stop if the link goes silent, so the car never keeps driving on a stale command.

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per UART bit (100 MHz / 9600 baud); minimum 4.
- TIMEOUT_CYCLES, 50000000, clk cycles without a valid byte before `cmd` is forced to CMD_STOP; 0 disables the timeout.
- CMD_MIN, 10, lowest accepted command code.
- CMD_MAX, 20, highest accepted command code.
- CMD_STOP, 10, code driven on reset and on timeout.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset. One clock; reset is synchronous and active-high.
- rx  input  1  raw UART line from the Bluetooth module; idles high; asynchronous to clk.
- cmd  output  8  current accepted command, registered.
- cmd_valid  output  1  one-cycle pulse whenever `cmd` is written (valid byte or timeout).
- rx_byte  output  8  last byte received with a good stop bit, accepted or not.
- bad_cmd  output  1  one-cycle pulse when a well-framed byte is outside CMD_MIN..CMD_MAX.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- **Reset values:** cmd=CMD_STOP, rx_byte=0, cmd_valid=bad_cmd=frame_err=0, FSM=IDLE, all counters 0.
  - Synchronizer flops reset to 1.
  - Reset mid-frame abandons the frame; no pulse is emitted.
- **Input sync:** `rx` passes through 2 flops to give rx_s. All decisions use rx_s.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE. Bit counter `bcnt` counts 0..CLKS_PER_BIT-1; bit index `bidx` counts 0..7.
- **IDLE:**
  - rx_s==0 -> START with bcnt=0.
- **START:**
  - At bcnt==CLKS_PER_BIT/2-1 (integer division), sample rx_s.
  - If 0 -> DATA with bcnt=0, bidx=0.
  - If 1 -> IDLE (glitch rejected, no pulse).
- **DATA:**
  - At bcnt==CLKS_PER_BIT-1, shift rx_s into bit `bidx`, LSB first, and reset bcnt.
  - After bidx==7 -> STOP.
- **STOP:**
  - At bcnt==CLKS_PER_BIT-1, sample rx_s.
  - If 1: rx_byte<=shift register, run the command decode below, then -> IDLE.
  - If 0: frame_err pulse, byte discarded, cmd unchanged, then -> WAIT_IDLE.
- **WAIT_IDLE:**
  - Stay until rx_s==1, then -> IDLE. This prevents a held-low line (break) from retriggering frames.
- **Command decode:** same cycle as the good stop sample; outputs are visible on the next clk edge.
  - Byte in CMD_MIN..CMD_MAX inclusive (unsigned): cmd<=byte, cmd_valid=1, timeout counter<=0.
  - Otherwise: bad_cmd=1; cmd and the timeout counter are unchanged.
  - A repeated identical valid byte still pulses cmd_valid and restarts the timeout.
- **Pulse widths:** all pulses are exactly 1 cycle; they never overlap each other except as noted below.
- **Timeout:**
  - 32-bit counter; increments each cycle while cmd!=CMD_STOP and TIMEOUT_CYCLES!=0.
  - Held at 0 while cmd==CMD_STOP.
  - On reaching TIMEOUT_CYCLES-1: cmd<=CMD_STOP, cmd_valid=1, counter<=0.
- **Simultaneous events:** if a valid byte completes in the same cycle the timeout fires, the byte wins.
  - cmd takes the byte value.
  - cmd_valid pulses once.
  - The counter clears.
- **Latency:** cmd changes 1 clk after the stop-bit sample, i.e. about 9.5 bit times + 3 cycles after the start-bit falling edge on `rx`.
- **Out-of-range bytes:** no saturation or arithmetic on bytes; out-of-range values are never passed to `cmd`.

Test Plan (CLKS_PER_BIT=16, TIMEOUT_CYCLES=1000):
- **Reset then valid byte:** release rst, send 0x0B (Forward) -> one cmd_valid pulse, cmd=11, rx_byte=0x0B, bad_cmd=0, frame_err=0; busy high from start bit until the stop sample.
- **Out-of-range bytes:** send 0x41, then 0x15 (21), then 0x09 -> three bad_cmd pulses, cmd stays 11, rx_byte follows each byte; then 0x14 (20) and 0x0A (10) are both accepted.
- **Framing error:** send 0x0C with stop bit low, hold rx low 100 cycles, then release -> one frame_err pulse, cmd unchanged, FSM in WAIT_IDLE until rx high; the next 0x0D decodes correctly to cmd=13.
- **Glitch rejection:** 4-cycle low pulse on rx -> no pulses, FSM returns to IDLE, cmd unchanged.
- **Timeout:** send 0x10 then idle -> exactly 1000 cycles after the cmd update, cmd=10 with one cmd_valid pulse; no further pulses while idle.
- **Timeout collision and reset mid-frame:**
  - Send 0x0F timed so the stop sample coincides with timeout expiry -> cmd=15, single cmd_valid.
  - Assert rst during bit 4 of a frame -> cmd=10, no pulses; the next full byte decodes normally.
